regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port register file that succeeds the single-write, two-read core register file. It adds:
- configurable width, depth and port counts;
- same-cycle write-to-read bypass;
- a per-register busy scoreboard for long-latency accelerator ops;
- a sequenced soft-clear engine.

It sits between decode (reads and allocations) and the writeback stages (ALU writeback and maths-unit writeback).

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of registers (power of two, >=4); AW = $clog2(NUM_REGS) is derived
NUM_RD, 2, number of read ports
NUM_WR, 2, number of write ports
ZERO_REG, 1, if 1, register 0 reads as 0 and ignores writes and allocations
BYPASS, 1, if 1, a read of an address being written this cycle returns the write data
DBG_IDX, 10, index of the register exported on dbg_reg

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous active-low reset
rd_addr  in  NUM_RD*AW  packed read addresses; port i = [i*AW +: AW]
rd_data  out  NUM_RD*DATA_W  packed combinational read data
rd_busy  out  NUM_RD  busy bit of each read address, combinational
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*AW  packed write addresses
wr_data  in  NUM_WR*DATA_W  packed write data
wr_ready  out  1  high when writes are accepted (engine IDLE)
alloc_en  in  1  mark alloc_addr busy (long-latency op issued)
alloc_addr  in  AW  register to mark busy
clr_req  in  1  start a soft clear sweep
clr_busy  out  1  high while the sweep runs
clr_done  out  1  one-cycle pulse when the sweep completes
dbg_reg  out  DATA_W  current contents of register DBG_IDX

Behaviour:
- Reset (rst=0, async):
  - all registers = 0 and all busy bits = 0;
  - state = IDLE, sweep index = 0;
  - clr_busy = 0, clr_done = 0, wr_ready = 1.
  - Reset asserted mid-sweep aborts the sweep immediately.
- Reads are combinational (0-cycle latency):
  - rd_data[i] = regs[rd_addr[i]];
  - forced to 0 when ZERO_REG=1 and the address is 0.
- Bypass (BYPASS=1, state IDLE): if any enabled write port targets rd_addr[i] this cycle, rd_data[i] returns that port's wr_data. The highest-index matching port wins. Address 0 is never bypassed when ZERO_REG=1.
- Writes take effect at the clock edge and are visible via the array on the next cycle.
  - Multiple ports writing the same address: the highest-index port wins.
  - Writes to address 0 are dropped when ZERO_REG=1.
- Scoreboard:
  - alloc_en sets busy[alloc_addr] at the edge.
  - Any accepted write clears busy[wr_addr].
  - If an allocation and a write hit the same address in one cycle, the allocation wins (busy = 1) and the data is still written.
  - Allocation to address 0 is ignored when ZERO_REG=1.
  - rd_busy[i] = busy[rd_addr[i]], pre-edge value; not bypassed.
- Soft-clear FSM, states IDLE, SWEEP, DONE:
  - IDLE -> SWEEP on clr_req; index loads 0.
  - In SWEEP, each cycle writes regs[index] = 0, clears busy[index] and increments index. After index = NUM_REGS-1 the FSM moves to DONE.
  - DONE: clr_done = 1 for exactly one cycle, then back to IDLE.
  - Total: NUM_REGS+1 cycles from the clr_req edge to the clr_done cycle.
  - clr_busy = 1 in SWEEP and DONE.
  - wr_ready = 0 in SWEEP and DONE. Writes and allocations presented then are dropped silently, bypass is disabled, and reads return array contents.
  - clr_req outside IDLE is ignored.
- Sweep index wraps naturally at NUM_REGS; it has no out-of-range state.
- dbg_reg = regs[DBG_IDX], with no bypass.

Test Plan:
- Reset then read: rst low, write port 0 addr 5 = 0xDEADBEEF, read addr 5 next cycle -> 0xDEADBEEF. Read addr 0 -> 0. A write to addr 0 of 0x1234 -> still reads 0.
- Bypass/collision: same cycle, wr port0 addr 7 = 0x11 and port1 addr 7 = 0x22, rd_addr0 = 7 -> rd_data0 = 0x22 that cycle, and regs[7] = 0x22 after the edge.
- Scoreboard: alloc addr 3 -> rd_busy = 1 next cycle. Write addr 3 -> busy 0 the cycle after. alloc and write to addr 4 in the same cycle -> busy 1 and data updated.
- Soft clear: fill all 32 registers with nonzero values and set busy on addr 9, then pulse clr_req -> clr_busy high for 33 cycles. clr_done pulses at cycle 33. A write issued mid-sweep is dropped. All registers = 0 and all busy = 0 afterwards.
- Async reset mid-sweep: assert rst at sweep index 12 -> clr_busy = 0 and all registers = 0 immediately, without waiting for the next clock edge. After release, wr_ready = 1.
- dbg_reg: write addr 10 = 0xCAFE0001 -> dbg_reg = 0xCAFE0001 the next cycle. Run with NUM_WR=3 and NUM_REGS=64 to confirm the parametrisation.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: bypassed combinational reads, prioritised writes,
// a per-register busy scoreboard and a sequenced soft-clear sweep.

module regfile_mp_rd #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int AW       = 5,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  logic [NUM_REGS-1:0]             busy,
    input  logic [AW-1:0]                   addr,
    input  logic [NUM_WR-1:0]               wv,
    input  logic [NUM_WR-1:0][AW-1:0]       wa,
    input  logic [NUM_WR-1:0][DATA_W-1:0]   wd,
    output logic [DATA_W-1:0]               data,
    output logic                            bsy
);
    // wv is already gated by IDLE and the zero-register rule, so bypass
    // inherits both without extra checks here.
    always_comb begin
        data = regs[addr];
        if (BYPASS != 0) begin
            for (int p = 0; p < NUM_WR; p++)
                if (wv[p] && wa[p] == addr) data = wd[p];
        end
        if (ZERO_REG != 0 && addr == '0) data = '0;
    end

    assign bsy = busy[addr];
endmodule

module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int DBG_IDX  = 10,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic                     wr_ready,
    input  logic                     alloc_en,
    input  logic [AW-1:0]            alloc_addr,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done,
    output logic [DATA_W-1:0]        dbg_reg
);
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    localparam logic [AW-1:0] LAST  = AW'(NUM_REGS - 1);
    localparam logic [AW-1:0] DBG_A = AW'(DBG_IDX);

    state_t                          state, state_nxt;
    logic [AW-1:0]                   idx;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             busy;

    logic [NUM_RD-1:0][AW-1:0]       ra;
    logic [NUM_RD-1:0][DATA_W-1:0]   rdv;
    logic [NUM_WR-1:0][AW-1:0]       wa;
    logic [NUM_WR-1:0][DATA_W-1:0]   wd;
    logic [NUM_WR-1:0]               wv;
    logic                            alloc_ok;
    logic                            idle;

    assign ra      = rd_addr;
    assign wa      = wr_addr;
    assign wd      = wr_data;
    assign rd_data = rdv;
    assign idle    = (state == IDLE);
    assign dbg_reg = regs[DBG_A];

    always_comb begin
        for (int p = 0; p < NUM_WR; p++)
            wv[p] = wr_en[p] && idle && !(ZERO_REG != 0 && wa[p] == '0);
        alloc_ok = alloc_en && idle && !(ZERO_REG != 0 && alloc_addr == '0);
    end

    // Later ports overwrite earlier ones; allocation lands last so it wins over a write clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '0;
            busy <= '0;
        end else if (state == SWEEP) begin
            regs[idx] <= '0;
            busy[idx] <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wv[p]) begin
                    regs[wa[p]] <= wd[p];
                    busy[wa[p]] <= 1'b0;
                end
            end
            if (alloc_ok) busy[alloc_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (state == SWEEP)               idx <= idx + 1'b1;
            else if (state == IDLE && clr_req) idx <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_ready  = 1'b0;
        clr_busy  = 1'b1;
        clr_done  = 1'b0;
        case (state)
            IDLE: begin
                wr_ready = 1'b1;
                clr_busy = 1'b0;
                if (clr_req) state_nxt = SWEEP;
            end
            SWEEP: if (idx == LAST) state_nxt = DONE;
            DONE: begin
                clr_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        regfile_mp_rd #(
            .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .AW(AW),
            .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
        ) u_rd (
            .regs(regs), .busy(busy), .addr(ra[r]),
            .wv(wv), .wa(wa), .wd(wd),
            .data(rdv[r]), .bsy(rd_busy[r])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default instance plus a 3-write, 64-entry instance.

module tb_regfile_mp;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int AW2 = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data;
    logic [1:0]      rd_busy;
    logic [1:0]      wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;
    logic            wr_ready, alloc_en, clr_req, clr_busy, clr_done;
    logic [AW-1:0]   alloc_addr;
    logic [DW-1:0]   dbg_reg;

    logic [2*AW2-1:0] rd_addr2;
    logic [2*DW-1:0]  rd_data2;
    logic [1:0]       rd_busy2;
    logic [2:0]       wr_en2;
    logic [3*AW2-1:0] wr_addr2;
    logic [3*DW-1:0]  wr_data2;
    logic             wr_ready2, alloc_en2, clr_req2, clr_busy2, clr_done2;
    logic [AW2-1:0]   alloc_addr2;
    logic [DW-1:0]    dbg_reg2;

    regfile_mp u_dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
        .dbg_reg(dbg_reg)
    );

    regfile_mp #(.NUM_REGS(64), .NUM_WR(3)) u_dut2 (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_busy(rd_busy2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .wr_ready(wr_ready2),
        .alloc_en(alloc_en2), .alloc_addr(alloc_addr2),
        .clr_req(clr_req2), .clr_busy(clr_busy2), .clr_done(clr_done2),
        .dbg_reg(dbg_reg2)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle1();
        wr_en = '0; alloc_en = 1'b0; clr_req = 1'b0;
    endtask

    task automatic wr(input int p, input int a, input logic [DW-1:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic wr2(input int p, input int a, input logic [DW-1:0] d);
        wr_en2[p] = 1'b1;
        wr_addr2[p*AW2 +: AW2] = AW2'(a);
        wr_data2[p*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] rdd(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    initial begin
        int n;
        rst = 1'b0;
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0; clr_req = 1'b0;
        rd_addr2 = '0; wr_en2 = '0; wr_addr2 = '0; wr_data2 = '0;
        alloc_en2 = 1'b0; alloc_addr2 = '0; clr_req2 = 1'b0;

        // reset state
        tick(); rd(0, 5); #1;
        chk("rst_rd5", rdd(0), 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_clr_done", clr_done, 0);
        chk("rst_dbg", dbg_reg, 0);
        tick(); rst = 1'b1;

        // write then read, with bypass in the write cycle
        tick(); wr(0, 5, 32'hDEADBEEF); rd(0, 5); #1;
        chk("byp_rd5", rdd(0), 32'hDEADBEEF);
        tick(); idle1(); rd(1, 0); #1;
        chk("arr_rd5", rdd(0), 32'hDEADBEEF);
        chk("rd0", rdd(1), 0);
        tick(); wr(0, 0, 32'h1234); rd(1, 0); #1;
        chk("byp_rd0", rdd(1), 0);
        tick(); idle1(); #1;
        chk("arr_rd0", rdd(1), 0);

        // same-address collision: higher port wins
        tick(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(0, 7); #1;
        chk("coll_byp", rdd(0), 32'h22);
        tick(); idle1(); #1;
        chk("coll_arr", rdd(0), 32'h22);

        // scoreboard
        tick(); alloc_en = 1'b1; alloc_addr = 5'd3; rd(0, 3); #1;
        chk("busy3_pre", rd_busy[0], 0);
        tick(); idle1(); #1;
        chk("busy3_set", rd_busy[0], 1);
        tick(); wr(1, 3, 32'h33); #1;
        chk("busy3_nobyp", rd_busy[0], 1);
        tick(); idle1(); #1;
        chk("busy3_clr", rd_busy[0], 0);
        tick(); wr(0, 4, 32'h44); alloc_en = 1'b1; alloc_addr = 5'd4; rd(1, 4);
        tick(); idle1(); #1;
        chk("busy4_alloc_wins", rd_busy[1], 1);
        chk("data4", rdd(1), 32'h44);
        tick(); alloc_en = 1'b1; alloc_addr = 5'd0; rd(1, 0);
        tick(); idle1(); #1;
        chk("busy0_ignored", rd_busy[1], 0);

        // debug export, no bypass
        tick(); wr(0, 10, 32'hCAFE0001); #1;
        chk("dbg_pre", dbg_reg, 0);
        tick(); idle1(); #1;
        chk("dbg", dbg_reg, 32'hCAFE0001);

        // 64-entry, 3-write-port instance
        tick(); wr2(0, 40, 32'h1); wr2(2, 40, 32'hA5A5); wr2(1, 63, 32'h77);
        rd_addr2[0 +: AW2] = 6'd40; #1;
        chk("p2_byp40", rd_data2[0 +: DW], 32'hA5A5);
        tick(); wr_en2 = '0; rd_addr2[AW2 +: AW2] = 6'd63; #1;
        chk("p2_arr40", rd_data2[0 +: DW], 32'hA5A5);
        chk("p2_arr63", rd_data2[DW +: DW], 32'h77);
        tick(); wr2(2, 10, 32'hBEEF);
        tick(); wr_en2 = '0; #1;
        chk("p2_dbg", dbg_reg2, 32'hBEEF);
        tick(); clr_req2 = 1'b1;
        n = 0;
        while (n < 100) begin
            tick(); clr_req2 = 1'b0; n++; #1;
            if (clr_done2) break;
        end
        chk("p2_sweep_len", n, 65);
        tick(); #1;
        chk("p2_cleared63", rd_data2[DW +: DW], 0);

        // fill, mark 9 busy, then sweep
        for (int a = 1; a < 32; a++) begin
            tick(); idle1(); wr(0, a, 32'h100 + a);
        end
        tick(); idle1(); alloc_en = 1'b1; alloc_addr = 5'd9;
        tick(); idle1(); rd(0, 31); rd(1, 9); #1;
        chk("fill31", rdd(0), 32'h11F);
        chk("fill_busy9", rd_busy[1], 1);
        tick(); clr_req = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            tick(); idle1();
            if (c == 5) begin
                wr(0, 2, 32'hBAD); alloc_en = 1'b1; alloc_addr = 5'd1; rd(0, 2);
                #1;
                chk("sweep_wr_ready", wr_ready, 0);
                chk("sweep_nobyp", rdd(0), 0);
            end
            #1;
            chk($sformatf("clr_busy_c%0d", c), clr_busy, (c <= 33));
            chk($sformatf("clr_done_c%0d", c), clr_done, (c == 33));
        end
        for (int a = 0; a < 32; a++) begin
            rd(0, a); rd(1, a); #1;
            chk($sformatf("swept_rd%0d", a), rdd(0), 0);
            chk($sformatf("swept_busy%0d", a), rd_busy[1], 0);
        end
        chk("post_wr_ready", wr_ready, 1);

        // async reset at sweep index 12
        tick(); wr(0, 20, 32'h55); wr(1, 25, 32'h66);
        tick(); idle1(); clr_req = 1'b1;
        for (int c = 0; c < 13; c++) begin
            tick(); clr_req = 1'b0;
        end
        rd(0, 20); rd(1, 25); #1;
        chk("pre_rst_rd20", rdd(0), 32'h55);
        chk("pre_rst_busy", clr_busy, 1);
        rst = 1'b0; #1;
        chk("arst_clr_busy", clr_busy, 0);
        chk("arst_rd20", rdd(0), 0);
        chk("arst_rd25", rdd(1), 0);
        chk("arst_dbg", dbg_reg, 0);
        tick(); rst = 1'b1;
        tick(); #1;
        chk("rel_wr_ready", wr_ready, 1);
        chk("rel_clr_busy", clr_busy, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
